// File: rtl/msrv32_pkg.sv
// Shared widths and the writeback slot record for the register-file
// writeback arbiter and its one-entry request slots.
package msrv32_pkg;

    localparam int XLEN    = 32;
    localparam int RA_W    = 5;
    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] addr;
        logic [XLEN-1:0] data;
    } wb_slot_t;

    // One bit per architectural register; a 32-entry map regardless of RA_W.
    function automatic logic [31:0] reg_onehot(input logic [RA_W-1:0] addr);
        reg_onehot = 32'd1 << addr;
    endfunction

endpackage

// File: rtl/msrv32_wb_slot.sv
// One-entry writeback holding slot. It drains on a grant and can be
// reloaded by its requester on that same edge.
module msrv32_wb_slot
    import msrv32_pkg::*;
(
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            flush_in,
    input  logic            valid_in,
    input  logic [RA_W-1:0] addr_in,
    input  logic [XLEN-1:0] data_in,
    input  logic            grant_in,
    output logic            ready_out,
    output wb_slot_t        slot_out
);

    wb_slot_t slot_q;
    logic     load;

    // Ready depends only on slot state, the grant and flush, never on valid_in.
    assign ready_out = !slot_q.valid | grant_in | flush_in;

    // Writes to x0 complete the handshake but are discarded here.
    assign load = valid_in & ready_out & !flush_in & (addr_in != '0);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            slot_q <= '0;
        end else if (flush_in) begin
            slot_q <= '0;
        end else if (load) begin
            slot_q.valid <= 1'b1;
            slot_q.addr  <= addr_in;
            slot_q.data  <= data_in;
        end else if (grant_in) begin
            slot_q.valid <= 1'b0;
        end
    end

    assign slot_out = slot_q;

endmodule

// File: rtl/msrv32_rf_wb_arbiter.sv
// Round-robin arbiter merging two writeback requesters onto the single
// register-file write port. XLEN/RA_W must match the msrv32_pkg values.
module msrv32_rf_wb_arbiter
    import msrv32_pkg::*;
#(
    parameter int XLEN = msrv32_pkg::XLEN,
    parameter int RA_W = msrv32_pkg::RA_W
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            req0_valid_in,
    input  logic [RA_W-1:0] req0_addr_in,
    input  logic [XLEN-1:0] req0_data_in,
    output logic            req0_ready_out,
    input  logic            req1_valid_in,
    input  logic [RA_W-1:0] req1_addr_in,
    input  logic [XLEN-1:0] req1_data_in,
    output logic            req1_ready_out,
    input  logic            flush_in,
    output logic            wr_en_out,
    output logic [RA_W-1:0] rd_addr_out,
    output logic [XLEN-1:0] rd_out,
    output logic [31:0]     pending_mask_out
);

    wb_slot_t slot0;
    wb_slot_t slot1;
    logic     grant0;
    logic     grant1;
    logic     last_grant;

    msrv32_wb_slot u_slot0 (
        .ms_riscv32_mp_clk_in (ms_riscv32_mp_clk_in),
        .ms_riscv32_mp_rst_in (ms_riscv32_mp_rst_in),
        .flush_in             (flush_in),
        .valid_in             (req0_valid_in),
        .addr_in              (req0_addr_in),
        .data_in              (req0_data_in),
        .grant_in             (grant0),
        .ready_out            (req0_ready_out),
        .slot_out             (slot0)
    );

    msrv32_wb_slot u_slot1 (
        .ms_riscv32_mp_clk_in (ms_riscv32_mp_clk_in),
        .ms_riscv32_mp_rst_in (ms_riscv32_mp_rst_in),
        .flush_in             (flush_in),
        .valid_in             (req1_valid_in),
        .addr_in              (req1_addr_in),
        .data_in              (req1_data_in),
        .grant_in             (grant1),
        .ready_out            (req1_ready_out),
        .slot_out             (slot1)
    );

    // On a tie the slot that did not win last time is served; flush grants nothing.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!flush_in) begin
            if (slot0.valid && (!slot1.valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (slot1.valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            wr_en_out   <= 1'b0;
            rd_addr_out <= '0;
            rd_out      <= '0;
        end else if (grant0) begin
            wr_en_out   <= 1'b1;
            rd_addr_out <= slot0.addr;
            rd_out      <= slot0.data;
        end else if (grant1) begin
            wr_en_out   <= 1'b1;
            rd_addr_out <= slot1.addr;
            rd_out      <= slot1.data;
        end else begin
            wr_en_out   <= 1'b0;
        end
    end

    // Registers with a write still queued or on the port; x0 is never pending.
    always_comb begin
        pending_mask_out = '0;
        if (slot0.valid) begin
            pending_mask_out = pending_mask_out | reg_onehot(slot0.addr);
        end
        if (slot1.valid) begin
            pending_mask_out = pending_mask_out | reg_onehot(slot1.addr);
        end
        if (wr_en_out) begin
            pending_mask_out = pending_mask_out | reg_onehot(rd_addr_out);
        end
        pending_mask_out[0] = 1'b0;
    end

endmodule

// File: tb/tb_msrv32_rf_wb_arbiter.sv
// Directed and random checks of the writeback arbiter against a
// cycle-level model of its slot and round-robin rules.
module tb_msrv32_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        flush;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd;
    logic [31:0] pending_mask;

    int errors = 0;
    int checks = 0;

    // Reference state: what each requester still owes, who won last, what is on the port.
    bit          m_known = 0;
    bit          m_full [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    int          m_last;
    bit          m_wr;
    logic [4:0]  m_rd_addr;
    logic [31:0] m_rd;

    msrv32_rf_wb_arbiter dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .req0_valid_in        (req0_valid),
        .req0_addr_in         (req0_addr),
        .req0_data_in         (req0_data),
        .req0_ready_out       (req0_ready),
        .req1_valid_in        (req1_valid),
        .req1_addr_in         (req1_addr),
        .req1_data_in         (req1_data),
        .req1_ready_out       (req1_ready),
        .flush_in             (flush),
        .wr_en_out            (wr_en),
        .rd_addr_out          (rd_addr),
        .rd_out               (rd),
        .pending_mask_out     (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelMask();
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 2; i++)
            if (m_full[i]) m = m | (32'd1 << m_addr[i]);
        if (m_wr) m = m | (32'd1 << m_rd_addr);
        m[0] = 1'b0;
        return m;
    endfunction

    // One full clock cycle: drive, check ready before the edge, advance the model, check outputs.
    task automatic applyStimulus(input bit rs, input bit fl,
                                 input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        int  g;
        bit  rdy0;
        bit  rdy1;
        @(negedge clk);
        rst = rs; flush = fl;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        g = -1;
        if (!fl) begin
            if (m_full[0] && m_full[1]) g = 1 - m_last;
            else if (m_full[0])         g = 0;
            else if (m_full[1])         g = 1;
        end
        rdy0 = !m_full[0] || g == 0 || fl;
        rdy1 = !m_full[1] || g == 1 || fl;
        if (m_known) begin
            checkOutput("ready0", 32'(req0_ready), 32'(rdy0));
            checkOutput("ready1", 32'(req1_ready), 32'(rdy1));
        end
        @(posedge clk);
        #1;
        if (rs) begin
            m_full[0] = 0; m_full[1] = 0;
            m_last = 1; m_wr = 0; m_rd_addr = '0; m_rd = '0;
            m_known = 1;
        end else if (fl) begin
            m_full[0] = 0; m_full[1] = 0;
            m_wr = 0;
        end else begin
            if (g >= 0) begin
                m_wr = 1; m_rd_addr = m_addr[g]; m_rd = m_data[g];
                m_full[g] = 0; m_last = g;
            end else begin
                m_wr = 0;
            end
            if (v0 && rdy0 && a0 != 0) begin m_full[0] = 1; m_addr[0] = a0; m_data[0] = d0; end
            if (v1 && rdy1 && a1 != 0) begin m_full[1] = 1; m_addr[1] = a1; m_data[1] = d1; end
        end
        if (m_known) begin
            checkOutput("wr_en", 32'(wr_en), 32'(m_wr));
            checkOutput("rd_addr", 32'(rd_addr), 32'(m_rd_addr));
            checkOutput("rd_data", rd, m_rd);
            checkOutput("pending_mask", pending_mask, modelMask());
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic resetCycle();
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        m_full[0] = 0; m_full[1] = 0; m_last = 1; m_wr = 0;

        resetCycle();
        resetCycle();
        checkOutput("rst_ready0", 32'(req0_ready), 32'd1);
        checkOutput("rst_ready1", 32'(req1_ready), 32'd1);
        checkOutput("rst_mask", pending_mask, 32'd0);

        // Single write to x5.
        applyStimulus(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        checkOutput("single_mask_c1", 32'(pending_mask[5]), 32'd1);
        idleCycle();
        checkOutput("single_wr", 32'(wr_en), 32'd1);
        checkOutput("single_addr", 32'(rd_addr), 32'd5);
        checkOutput("single_data", rd, 32'hDEADBEEF);
        idleCycle();
        checkOutput("single_done_wr", 32'(wr_en), 32'd0);
        checkOutput("single_done_mask", pending_mask, 32'd0);

        // Tie after reset: requester 0 first.
        resetCycle();
        applyStimulus(0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        idleCycle();
        checkOutput("tie_first", 32'(rd_addr), 32'd3);
        idleCycle();
        checkOutput("tie_second", 32'(rd_addr), 32'd4);
        applyStimulus(0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        idleCycle();
        idleCycle();
        idleCycle();

        // Write to x0 is swallowed.
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF);
        checkOutput("x0_mask", pending_mask, 32'd0);
        idleCycle();
        checkOutput("x0_wr", 32'(wr_en), 32'd0);

        // Back-to-back stream from requester 0.
        for (int i = 1; i <= 8; i++)
            applyStimulus(0, 0, 1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 32'd0);
        checkOutput("b2b_last_inflight", 32'(rd_addr), 32'd7);
        idleCycle();
        checkOutput("b2b_last", 32'(rd_addr), 32'd8);
        idleCycle();

        // Flush with both slots full, then a tie.
        applyStimulus(0, 0, 1, 5'd6, 32'h66, 1, 5'd7, 32'h77);
        applyStimulus(0, 1, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA);
        checkOutput("flush_wr", 32'(wr_en), 32'd0);
        checkOutput("flush_mask", pending_mask, 32'd0);
        applyStimulus(0, 0, 1, 5'd9, 32'h99, 1, 5'd10, 32'hAA);
        idleCycle();
        idleCycle();
        idleCycle();

        // Reset while the port is writing.
        applyStimulus(0, 0, 1, 5'd2, 32'h1234, 0, 5'd0, 32'd0);
        idleCycle();
        checkOutput("prerst_wr", 32'(wr_en), 32'd1);
        resetCycle();
        checkOutput("rst_kill_wr", 32'(wr_en), 32'd0);
        checkOutput("rst_kill_data", rd, 32'd0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
